// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 16-bit Fibonacci LFSR among NUM_REQ clients.
// Each grant steps the LFSR STEPS times, then presents the word under a valid/ack handshake.
module lfsr_rng_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          STEPS    = 4,
  parameter logic [15:0] RST_SEED = 16'h1001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_load,
  input  logic [15:0]        seed_value,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rnd_ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  output logic               busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  localparam logic [7:0]       STEP_LAST = 8'(STEPS - 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [1:0]         state_q,     state_d;
  logic [15:0]        lfsr_q,      lfsr_d;
  logic [NUM_REQ-1:0] gnt_q,       gnt_d;
  logic [PTR_W-1:0]   gnt_idx_q,   gnt_idx_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [7:0]         step_cnt_q,  step_cnt_d;
  logic               rnd_valid_q, rnd_valid_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic               owner_req;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first, otherwise paths
    // that skip an assignment infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign owner_req = req[gnt_idx_q];

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    step_cnt_d  = step_cnt_q;
    rnd_valid_d = rnd_valid_q;

    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          // A zero seed would lock the LFSR up, so fall back to the reset seed.
          lfsr_d = (seed_value == 16'h0000) ? RST_SEED : seed_value;
        end else if (win_found) begin
          gnt_d      = NUM_REQ'(1) << win_idx;
          gnt_idx_d  = win_idx;
          step_cnt_d = STEP_LAST;
          state_d    = S_STEP;
        end
      end

      S_STEP: begin
        if (!owner_req) begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          rnd_valid_d = 1'b0;
        end else begin
          lfsr_d = lfsr_next(lfsr_q);
          if (step_cnt_q == 8'd0) begin
            state_d     = S_VALID;
            rnd_valid_d = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q - 8'd1;
          end
        end
      end

      S_VALID: begin
        // An abort leaves rr_ptr alone so the same client re-wins on reassert.
        if (!owner_req) begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          rnd_valid_d = 1'b0;
        end else if (rnd_ack) begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          rnd_valid_d = 1'b0;
          rr_ptr_d    = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + PTR_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= RST_SEED;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      step_cnt_q  <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      step_cnt_q  <= step_cnt_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = lfsr_q;
  assign busy      = (state_q != S_IDLE);

endmodule
